// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among NumReq byte producers.
// Ports: Clk/Rst (async, active-high); Req_Valid/Req_Data in, Req_Ack one-hot accept pulse out;
// Tx_Data/Tx_DataValid to the transmitter, TxDone back from it; Busy, Grant_Id, Tx_Timeout status.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN; otherwise Tx_Timeout is tied low.
module uart_tx_arbiter #(
    parameter int NumReq        = 4,
    parameter int TimeoutCycles = 131072
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NumReq-1:0]     Req_Valid,
    input  logic [8*NumReq-1:0]   Req_Data,
    output logic [NumReq-1:0]     Req_Ack,
    output logic [7:0]            Tx_Data,
    output logic                  Tx_DataValid,
    input  logic                  TxDone,
    output logic                  Busy,
    output logic [2:0]            Grant_Id,
    output logic                  Tx_Timeout
);
    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;
    state_t            state_q;
    logic [2:0]        ptr_q, gid_q, win_d, hi, lo, ptr_d;
    logic [NumReq-1:0] ack_q, ack_d;
    logic [7:0]        data_q, data_d;
    logic              hi_found, txdone_q, valid_q, busy_q, done;
    if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 2 || TimeoutCycles > 262144) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameters");
    end
    // Scan downward so the lowest set index wins: among indices >= ptr first, else wrap to the lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi       = '0;
        lo       = '0;
        for (int j = NumReq - 1; j >= 0; j--) begin
            if (Req_Valid[j]) begin
                lo = 3'(j);
                if (3'(j) >= ptr_q) begin
                    hi       = 3'(j);
                    hi_found = 1'b1;
                end
            end
        end
        win_d  = hi_found ? hi : lo;
        ptr_d  = (win_d == 3'(NumReq - 1)) ? 3'd0 : win_d + 3'd1;
        ack_d  = '0;
        data_d = '0;
        for (int j = 0; j < NumReq; j++) begin
            if (3'(j) == win_d) begin
                ack_d[j] = 1'b1;
                data_d   = Req_Data[8*j +: 8];
            end
        end
    end
    assign done = TxDone & ~txdone_q;
`ifdef UART_ARB_TIMEOUT_EN
    logic [17:0] cnt_q;
    logic        to_q;
    assign Tx_Timeout = to_q;
`else
    assign Tx_Timeout = 1'b0;
`endif
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            txdone_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            gid_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_q     <= 1'b0;
            cnt_q    <= '0;
`endif
        end else begin
            txdone_q <= TxDone;
            ack_q    <= '0;
            valid_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            to_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|Req_Valid) begin
                        data_q  <= data_d;
                        gid_q   <= win_d;
                        ack_q   <= ack_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        ptr_q   <= ptr_d;
                        state_q <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_q <= cnt_q + 18'd1;
                    if (done) begin
                        state_q <= GAP;
                    end else if (cnt_q == 18'(TimeoutCycles - 1)) begin
                        to_q    <= 1'b1;
                        state_q <= GAP;
                    end
`else
                    if (done) state_q <= GAP;
`endif
                end
                GAP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign Req_Ack      = ack_q;
    assign Tx_Data      = data_q;
    assign Tx_DataValid = valid_q;
    assign Busy         = busy_q;
    assign Grant_Id     = gid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter in its default build.
module tb_uart_tx_arbiter;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [3:0]  Req_Valid = '0;
    logic [31:0] Req_Data = 32'hD3C2A5B0;
    logic        TxDone = 1'b0;
    logic [3:0]  Req_Ack;
    logic [7:0]  Tx_Data;
    logic        Tx_DataValid, Busy, Tx_Timeout;
    logic [2:0]  Grant_Id;
    int checks = 0;
    int errors = 0;
    logic [7:0] bytes [4] = '{8'hB0, 8'hA5, 8'hC2, 8'hD3};
    uart_tx_arbiter #(.NumReq(4), .TimeoutCycles(64)) dut (
        .Clk(Clk), .Rst(Rst), .Req_Valid(Req_Valid), .Req_Data(Req_Data), .Req_Ack(Req_Ack),
        .Tx_Data(Tx_Data), .Tx_DataValid(Tx_DataValid), .TxDone(TxDone), .Busy(Busy),
        .Grant_Id(Grant_Id), .Tx_Timeout(Tx_Timeout)
    );
    always #5 Clk = ~Clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask
    task automatic all_zero(input string tag);
        check({tag, "_data"}, 32'(Tx_Data), 32'h00);
        check({tag, "_valid"}, 32'(Tx_DataValid), 32'h0);
        check({tag, "_ack"}, 32'(Req_Ack), 32'h0);
        check({tag, "_busy"}, 32'(Busy), 32'h0);
        check({tag, "_gid"}, 32'(Grant_Id), 32'h0);
        check({tag, "_tmo"}, 32'(Tx_Timeout), 32'h0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1);
    end
    initial begin
        repeat (2) tick;
        all_zero("reset");
        Rst = 1'b0;
        tick;
        check("idle_busy", 32'(Busy), 32'h0);
        Req_Valid = 4'b0010;
        tick;
        check("single_ack", 32'(Req_Ack), 32'h2);
        check("single_valid", 32'(Tx_DataValid), 32'h1);
        check("single_data", 32'(Tx_Data), 32'hA5);
        check("single_gid", 32'(Grant_Id), 32'h1);
        check("single_busy", 32'(Busy), 32'h1);
        Req_Valid = 4'b0000;
        tick;
        check("single_ack_off", 32'(Req_Ack), 32'h0);
        check("single_valid_off", 32'(Tx_DataValid), 32'h0);
        repeat (3) tick;
        check("single_hold", 32'(Tx_Data), 32'hA5);
        check("single_busy_hold", 32'(Busy), 32'h1);
        TxDone = 1'b1;
        tick;
        check("gap_busy", 32'(Busy), 32'h1);
        TxDone = 1'b0;
        tick;
        check("idle_busy_low", 32'(Busy), 32'h0);
        check("data_kept", 32'(Tx_Data), 32'hA5);
        Req_Valid = 4'b1000;
        tick;
        check("wrap_gid3", 32'(Grant_Id), 32'h3);
        check("wrap_ack3", 32'(Req_Ack), 32'h8);
        Req_Valid = 4'b1001;
        tick;
        check("ignored_in_wait", 32'(Req_Ack), 32'h0);
        TxDone = 1'b1;
        tick;
        tick;
        TxDone = 1'b0;
        check("held_done_busy", 32'(Busy), 32'h0);
        check("held_done_novalid", 32'(Tx_DataValid), 32'h0);
        tick;
        check("wrap_gid0", 32'(Grant_Id), 32'h0);
        check("wrap_ack0", 32'(Req_Ack), 32'h1);
        check("wrap_data0", 32'(Tx_Data), 32'hB0);
        Req_Valid = 4'b1000;
        TxDone = 1'b1;
        tick;
        tick;
        tick;
        check("level_grant_gid", 32'(Grant_Id), 32'h3);
        check("level_grant_valid", 32'(Tx_DataValid), 32'h1);
        tick;
        check("level_no_done_busy", 32'(Busy), 32'h1);
        TxDone = 1'b0;
        tick;
        check("level_still_wait", 32'(Busy), 32'h1);
        check("level_no_ack", 32'(Req_Ack), 32'h0);
        Req_Valid = 4'b0001;
        TxDone = 1'b1;
        tick;
        tick;
        TxDone = 1'b0;
        tick;
        check("pre_reset_gid", 32'(Grant_Id), 32'h0);
        Req_Valid = 4'b0000;
        tick;
        #3 Rst = 1'b1;
        #1 all_zero("async_rst");
        tick;
        Rst = 1'b0;
        Req_Valid = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            tick;
            check($sformatf("rr%0d_gid", f), 32'(Grant_Id), 32'(f % 4));
            check($sformatf("rr%0d_ack", f), 32'(Req_Ack), 32'(4'b0001 << (f % 4)));
            check($sformatf("rr%0d_valid", f), 32'(Tx_DataValid), 32'h1);
            check($sformatf("rr%0d_data", f), 32'(Tx_Data), 32'(bytes[f % 4]));
            tick;
            check($sformatf("rr%0d_low1", f), 32'(Tx_DataValid), 32'h0);
            TxDone = 1'b1;
            tick;
            check($sformatf("rr%0d_low2", f), 32'(Tx_DataValid), 32'h0);
            TxDone = 1'b0;
            tick;
            check($sformatf("rr%0d_low3", f), 32'(Tx_DataValid), 32'h0);
            check($sformatf("rr%0d_idle", f), 32'(Busy), 32'h0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
